data_compressor: RTL and testbench
==================================

# data_compressor

Reduces a 30-bit RGB (3×10) Avalon-ST video stream to 12-bit RGB (3×4) for the 12-bit output path. It rounds each channel and saturates the result, with optional 2×2 ordered dithering driven by pixel/line position counters. It sits at the sink end of the 30-bit processing chain, is registered, and sustains full throughput with a skid buffer on the backpressure path.

## Interface
- INITIAL_DATA_WIDTH, 30, input beat width (3×10-bit channels, R in [29:20], G in [19:10], B in [9:0])
- FINAL_DATA_WIDTH, 12, output beat width (3×4-bit channels, R in [11:8], G in [7:4], B in [3:0])
- IMG_WIDTH, 640, pixels per line; sets the column-counter wrap
- DITHER_EN, 1, 1 = Bayer dither offsets, 0 = plain round-half-up
- clock_clk  in  1  single clock; all logic rising-edge
- reset  in  1  synchronous, active-high
- data_in  in  30  input pixel
- sop_in / eop_in  in  1  packet start / end, qualified by the input handshake
- valid_in  in  1  input beat valid
- ready_out  out  1  block can accept an input beat
- data_out  out  12  compressed pixel
- sop_out / eop_out  out  1  packet flags, aligned with data_out
- valid_out  out  1  output beat valid
- ready_in  in  1  downstream accepts

## Operation
- Input accept: valid_in && ready_out. Output transfer: valid_out && ready_in.
- Per channel c (10 bits): s = c + off, 11 bits wide; result = 4'hF if s > 1023, else s[9:6].
- DITHER_EN=0: off = 32.
- DITHER_EN=1: off = M×16 + 8, with M indexed by (row parity y, column parity x): M[0][0]=0, M[0][1]=2, M[1][0]=3, M[1][1]=1. This gives offsets 8, 40, 56, 24.
- Position counters advance only on accepted beats:
  - A beat with sop_in has col=0, row=0. After it, col=1, or col wraps per the rule below if IMG_WIDTH=1.
  - Otherwise col increments. At col = IMG_WIDTH−1, col wraps to 0 and the row parity toggles.
- eop_in does not affect the counters. A sop arriving mid-packet (no prior eop) restarts the counters and is passed through unchanged; no error flag.
- The offset uses the counter values of the beat being accepted.
- sop and eop propagate with their beat.
- Skid buffer holds 1 entry:
  - ready_out is a register, equal to NOT skid_full.
  - A beat accepted while the output register is stalled goes to the skid.
  - When the output drains, the skid moves to the output register before any new input.

## Timing
- Reset values: valid_out=0, data_out=0, sop_out=0, eop_out=0, ready_out=0, skid empty, col=0, row=0.
- ready_out rises to 1 on the first edge after reset deasserts.
- Latency: accept at edge N → valid_out with data at edge N+1 (1 cycle).
- Throughput: 1 beat per clock while ready_in is held high.
- Stall: while valid_out && !ready_in, data_out, sop_out, eop_out and valid_out hold stable.
  - At most one further beat is accepted (into the skid).
  - ready_out falls on the next edge.
- Skid release: ready_in high with the skid full → skid beat is presented next cycle, and ready_out returns to 1 on that same edge.
- Reset mid-packet: all state clears on that edge, and in-flight beats are dropped. No partial packet is emitted afterwards; output resumes at the next sop_in.
- valid_in ignored while ready_out=0.

## Structure
- Package image_stream_pkg holds:
  - channel widths (10, 4)
  - the Bayer matrix constant
  - the round/saturate function (10-bit value + offset → 4-bit)
- Sub-module stream_skid_buffer: generic-width 1-entry skid plus output register, carrying {data, sop, eop}. The compressor datapath feeds its input side.
- Top level holds the counters, offset selection and the three channel reducers.

## Test plan
- Reset: hold reset 3 cycles with valid_in=1 → all outputs 0, ready_out=0; ready_out=1 one cycle after release.
- Saturation: DITHER_EN=0, data_in=30'h3FFFFFFF with sop=eop=1 → data_out=12'hFFF one cycle later, with sop_out=eop_out=1.
- Rounding: DITHER_EN=0, each channel 10'h200 → 12'h888; each channel 10'h1DF → 12'h777.
- Dither pattern: DITHER_EN=1, IMG_WIDTH=2, all channels 10'h1F0, 4 beats starting with sop:
  - required outputs 12'h777, 12'h888, 12'h888, 12'h888 (offsets 8/40/56/24)
  - a second sop restarts at 12'h777.
- Backpressure: stream 8 beats, drop ready_in for 3 cycles mid-stream, assert randomly after → no loss, duplication or reorder; outputs stable while stalled; ready_out low exactly while the skid is full.
- Reset mid-packet: reset after the 3rd beat of a 6-beat packet → no outputs after reset until a new sop. The new packet's first beat uses offset 8.

Source files
------------

// File: rtl/image_stream_pkg.sv
// Shared definitions for the RGB stream reducers: channel widths, the 2x2 Bayer
// matrix and the round/saturate helper.
package image_stream_pkg;

    localparam int unsigned IN_CH_W  = 10;
    localparam int unsigned OUT_CH_W = 4;

    // Indexed [row parity][column parity]
    localparam logic [1:0] BAYER [2][2] = '{'{2'd0, 2'd2}, '{2'd3, 2'd1}};

    function automatic logic [OUT_CH_W-1:0] round_sat(input logic [IN_CH_W-1:0] c,
                                                      input logic [5:0]         off);
        logic [IN_CH_W:0] s;
        s = {1'b0, c} + (IN_CH_W + 1)'(off);
        if (s[IN_CH_W])
            return '1;
        return s[IN_CH_W-1 -: OUT_CH_W];
    endfunction

endpackage

// File: rtl/stream_skid_buffer.sv
// One-entry skid buffer with registered output and registered upstream ready;
// a buffered beat always drains before any new upstream beat.
module stream_skid_buffer #(
    parameter int unsigned WIDTH = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] up_data,
    input  logic             up_valid,
    output logic             up_ready,
    output logic [WIDTH-1:0] dn_data,
    output logic             dn_valid,
    input  logic             dn_ready
);

    logic [WIDTH-1:0] skid_data;
    logic             skid_full;
    logic             take;
    logic             drain;

    assign take  = up_valid && up_ready;
    assign drain = !dn_valid || dn_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            dn_data   <= '0;
            dn_valid  <= 1'b0;
            skid_data <= '0;
            skid_full <= 1'b0;
            up_ready  <= 1'b0;
        end else if (drain) begin
            // up_ready is low whenever the skid is full, so take cannot collide here
            if (skid_full) begin
                dn_data   <= skid_data;
                dn_valid  <= 1'b1;
                skid_full <= 1'b0;
            end else begin
                dn_valid <= take;
                if (take)
                    dn_data <= up_data;
            end
            up_ready <= 1'b1;
        end else begin
            if (take) begin
                skid_data <= up_data;
                skid_full <= 1'b1;
            end
            up_ready <= !(skid_full || take);
        end
    end

endmodule

// File: rtl/data_compressor.sv
// 30-bit to 12-bit RGB stream reducer: per-channel round/saturate with optional
// position-driven 2x2 ordered dither, registered through a skid buffer.
module data_compressor #(
    parameter int unsigned INITIAL_DATA_WIDTH = 30,
    parameter int unsigned FINAL_DATA_WIDTH   = 12,
    parameter int unsigned IMG_WIDTH          = 640,
    parameter int unsigned DITHER_EN          = 1
) (
    input  logic                          clock_clk,
    input  logic                          reset,
    input  logic [INITIAL_DATA_WIDTH-1:0] data_in,
    input  logic                          sop_in,
    input  logic                          eop_in,
    input  logic                          valid_in,
    output logic                          ready_out,
    output logic [FINAL_DATA_WIDTH-1:0]   data_out,
    output logic                          sop_out,
    output logic                          eop_out,
    output logic                          valid_out,
    input  logic                          ready_in
);
    import image_stream_pkg::*;

    localparam int unsigned     COL_W    = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);

    logic [COL_W-1:0]            col;
    logic [COL_W-1:0]            col_cur;
    logic                        row;
    logic                        row_cur;
    logic                        accept;
    logic [5:0]                  off;
    logic [FINAL_DATA_WIDTH-1:0] pixel;
    logic [FINAL_DATA_WIDTH+1:0] beat_out;

    assign accept = valid_in && ready_out;

    // A sop beat sits at (0,0) regardless of where the previous packet left off
    always_comb begin
        col_cur = sop_in ? '0 : col;
        row_cur = sop_in ? 1'b0 : row;
        if (DITHER_EN != 0)
            off = {BAYER[row_cur][col_cur[0]], 4'd8};
        else
            off = 6'd32;
        pixel = {round_sat(data_in[3*IN_CH_W-1 -: IN_CH_W], off),
                 round_sat(data_in[2*IN_CH_W-1 -: IN_CH_W], off),
                 round_sat(data_in[IN_CH_W-1   -: IN_CH_W], off)};
    end

    always_ff @(posedge clock_clk) begin
        if (reset) begin
            col <= '0;
            row <= 1'b0;
        end else if (accept) begin
            if (col_cur == COL_LAST) begin
                col <= '0;
                row <= ~row_cur;
            end else begin
                col <= col_cur + COL_W'(1);
                row <= row_cur;
            end
        end
    end

    stream_skid_buffer #(
        .WIDTH(FINAL_DATA_WIDTH + 2)
    ) u_skid (
        .clk      (clock_clk),
        .reset    (reset),
        .up_data  ({pixel, sop_in, eop_in}),
        .up_valid (valid_in),
        .up_ready (ready_out),
        .dn_data  (beat_out),
        .dn_valid (valid_out),
        .dn_ready (ready_in)
    );

    assign {data_out, sop_out, eop_out} = beat_out;

endmodule

// File: tb/tb_data_compressor.sv
// Scoreboard bench: three parameterisations share one stimulus stream; expected
// beats come from an arithmetic model of the rounding/dither rules.
module tb_data_compressor;

    logic        clk;
    logic        reset;
    logic [29:0] data_in;
    logic        sop_in;
    logic        eop_in;
    logic        valid_in;
    logic        ready_in;

    logic [11:0] dout [3];
    logic        vout [3];
    logic        sopo [3];
    logic        eopo [3];
    logic        rdy  [3];

    // instance 0: plain rounding; 1: dither, 2-pixel lines; 2: dither, 3-pixel lines
    data_compressor #(.IMG_WIDTH(640), .DITHER_EN(0)) dut_plain (
        .clock_clk(clk), .reset(reset), .data_in(data_in), .sop_in(sop_in), .eop_in(eop_in),
        .valid_in(valid_in), .ready_out(rdy[0]), .data_out(dout[0]), .sop_out(sopo[0]),
        .eop_out(eopo[0]), .valid_out(vout[0]), .ready_in(ready_in));
    data_compressor #(.IMG_WIDTH(2), .DITHER_EN(1)) dut_dith2 (
        .clock_clk(clk), .reset(reset), .data_in(data_in), .sop_in(sop_in), .eop_in(eop_in),
        .valid_in(valid_in), .ready_out(rdy[1]), .data_out(dout[1]), .sop_out(sopo[1]),
        .eop_out(eopo[1]), .valid_out(vout[1]), .ready_in(ready_in));
    data_compressor #(.IMG_WIDTH(3), .DITHER_EN(1)) dut_dith3 (
        .clock_clk(clk), .reset(reset), .data_in(data_in), .sop_in(sop_in), .eop_in(eop_in),
        .valid_in(valid_in), .ready_out(rdy[2]), .data_out(dout[2]), .sop_out(sopo[2]),
        .eop_out(eopo[2]), .valid_out(vout[2]), .ready_in(ready_in));

    int          widths [3] = '{640, 2, 3};
    bit          dith   [3] = '{1'b0, 1'b1, 1'b1};
    logic [13:0] sb [3][$];
    int          n_pass = 0;
    int          n_total = 0;
    int          beat_idx = 0;
    int          rmode = 0;
    int          inflight [3];
    bit          stall_prev [3];
    bit          post [3];
    logic [15:0] prev [3];
    bit          rst_seen = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req)
            n_pass++;
        else
            $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, req, $time);
    endtask

    // Position within the packet: column = n mod width, row parity = (n div width) mod 2.
    function automatic logic [11:0] model(input int w, input bit d_en, input logic [29:0] d,
                                          input int n);
        int          col, row, off, v;
        logic [11:0] r;
        logic [9:0]  c;
        col = n % w;
        row = (n / w) % 2;
        if (!d_en) off = 32;
        else if (row == 0) off = (col % 2 == 0) ? 8 : 40;
        else off = (col % 2 == 0) ? 56 : 24;
        r = '0;
        for (int ch = 0; ch < 3; ch++) begin
            c = d[ch*10 +: 10];
            v = (int'(c) + off) / 64;
            if (v > 15) v = 15;
            r[ch*4 +: 4] = 4'(v);
        end
        return r;
    endfunction

    initial begin
        ready_in = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0:       ready_in = 1'b1;
                1:       ready_in = 1'($urandom_range(0, 1));
                default: ready_in = 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                if (rst_seen)
                    chk($sformatf("reset_state%0d", k), {16'b0, vout[k], sopo[k], eopo[k], rdy[k], dout[k]}, 32'b0);
                inflight[k] = 0;
                stall_prev[k] = 0;
                post[k] = 1;
            end else begin
                if (post[k]) begin
                    chk($sformatf("ready_after_reset%0d", k), {31'b0, rdy[k]}, 32'b0);
                    post[k] = 0;
                end else begin
                    chk($sformatf("ready_vs_skid%0d", k), {31'b0, rdy[k]}, {31'b0, inflight[k] < 2});
                end
                if (stall_prev[k])
                    chk($sformatf("stall_hold%0d", k), {16'b0, vout[k], sopo[k], eopo[k], 1'b0, dout[k]}, {16'b0, prev[k]});
                if (vout[k] && ready_in) begin
                    if (sb[k].size() == 0)
                        chk($sformatf("unexpected_output%0d", k), 32'd1, 32'd0);
                    else
                        chk($sformatf("beat%0d", k), {18'b0, dout[k], sopo[k], eopo[k]}, {18'b0, sb[k].pop_front()});
                end
                inflight[k] = inflight[k] + ((valid_in && rdy[k]) ? 1 : 0) - ((vout[k] && ready_in) ? 1 : 0);
                stall_prev[k] = vout[k] && !ready_in;
                prev[k] = {vout[k], sopo[k], eopo[k], 1'b0, dout[k]};
            end
        end
        rst_seen = reset;
    end

    task automatic send(input logic [29:0] d, input bit s, input bit e,
                        input bit ov0 = 0, input logic [11:0] x0 = 0,
                        input bit ov1 = 0, input logic [11:0] x1 = 0);
        bit acc;
        int waited;
        acc = 0;
        waited = 0;
        data_in = d;
        sop_in = s;
        eop_in = e;
        valid_in = 1'b1;
        while (!acc) begin
            @(negedge clk);
            acc = rdy[0];
            if (acc) begin
                if (s) beat_idx = 0;
                sb[0].push_back({ov0 ? x0 : model(widths[0], dith[0], d, beat_idx), s, e});
                sb[1].push_back({ov1 ? x1 : model(widths[1], dith[1], d, beat_idx), s, e});
                sb[2].push_back({model(widths[2], dith[2], d, beat_idx), s, e});
                beat_idx++;
            end
            @(posedge clk);
            #1;
            if (!acc) begin
                waited++;
                if (waited > 100) begin
                    chk("accept_timeout", 32'd0, 32'd1);
                    break;
                end
            end
        end
        valid_in = 1'b0;
    endtask

    task automatic do_reset(input int cycles, input bit vin);
        @(posedge clk);
        #1;
        reset = 1'b1;
        valid_in = vin;
        data_in = '1;
        sop_in = 1'b1;
        eop_in = 1'b1;
        for (int k = 0; k < 3; k++) sb[k].delete();
        beat_idx = 0;
        repeat (cycles) @(posedge clk);
        #1;
        reset = 1'b0;
        valid_in = 1'b0;
    endtask

    function automatic logic [29:0] rand_pix();
        logic [29:0] p;
        p = 30'($urandom);
        case ($urandom_range(0, 7))
            0: p = '1;
            1: p = '0;
            2: p = {3{10'h3E0}};
            default: ;
        endcase
        return p;
    endfunction

    initial begin
        reset = 1'b1;
        valid_in = 1'b0;
        data_in = '0;
        sop_in = 1'b0;
        eop_in = 1'b0;
        do_reset(3, 1'b1);
        repeat (2) @(posedge clk);
        #1;

        send(30'h3FFFFFFF, 1, 1, 1, 12'hFFF, 1, 12'hFFF);
        send({3{10'h200}}, 1, 1, 1, 12'h888);
        send({3{10'h1DF}}, 1, 1, 1, 12'h777);

        send({3{10'h1F0}}, 1, 0, 0, 0, 1, 12'h777);
        send({3{10'h1F0}}, 0, 0, 0, 0, 1, 12'h888);
        send({3{10'h1F0}}, 0, 0, 0, 0, 1, 12'h888);
        send({3{10'h1F0}}, 0, 1, 0, 0, 1, 12'h888);
        send({3{10'h1F0}}, 1, 1, 0, 0, 1, 12'h777);

        fork
            begin
                for (int i = 0; i < 8; i++) send(rand_pix(), i == 0, i == 7);
            end
            begin
                repeat (3) @(posedge clk);
                @(negedge clk);
                rmode = 2;
                repeat (3) @(negedge clk);
                rmode = 1;
            end
        join

        rmode = 1;
        for (int i = 0; i < 3; i++) send(rand_pix(), i == 0, 0);
        do_reset(2, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        send({3{10'h1F0}}, 1, 0, 0, 0, 1, 12'h777);
        send(rand_pix(), 0, 0);
        send(rand_pix(), 0, 1);

        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            send(rand_pix(), $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
        end

        rmode = 0;
        for (int i = 0; i < 50; i++) begin
            if (sb[0].size() + sb[1].size() + sb[2].size() == 0) break;
            @(posedge clk);
        end
        repeat (2) @(posedge clk);
        chk("drain", 32'(sb[0].size() + sb[1].size() + sb[2].size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running, required finished");
        $fatal(1, "timeout");
    end

endmodule
